dadda_rows_4x4_pipe: RTL
========================

// Module: dadda_rows_4x4_pipe
// PURPOSE
//  Upstream feeder for the 8-bit carry-select final adder in the dadda_simple multiplier.
//  Accepts two unsigned 4-bit operands and forms the 16 partial products.
//  Dadda-reduces them to two 8-bit rows (row_a, row_b) and presents them on a registered,
//  elastic valid/ready output. The downstream adder computes product = row_a + row_b, cin=0.
//  Two-entry pipeline: S1 holds registered operands, S2 holds reduced rows. Full throughput, backpressure-safe.
// PARAMETERS
//  TAG_W   4   width of sideband tag carried alongside each operation (>=1)
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      synchronous active-low reset, sampled on posedge clk
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept operands this cycle
//  in_a       in   4      multiplicand, unsigned
//  in_b       in   4      multiplier, unsigned
//  in_tag     in   TAG_W  sideband, returned unchanged with the result
//  out_valid  out  1      rows valid
//  out_ready  in   1      downstream adder accepts rows
//  row_a      out  8      reduced row 0
//  row_b      out  8      reduced row 1
//  out_tag    out  TAG_W  tag of the operation on row_a/row_b
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): s1_valid=0, s2_valid=0, out_valid=0; row_a, row_b, out_tag cleared to 0.
//    Reset overrides any handshake in the same cycle. In-flight operations are dropped, never emitted.
//  - Handshake: a transfer occurs when valid&&ready at posedge. in_valid may not depend on in_ready.
//    Data is ignored while valid=0.
//  - out_valid=s2_valid. While out_valid=1 and out_ready=0, row_a, row_b and out_tag hold stable.
//  - S2 advance: s2_load = s1_valid && (!s2_valid || out_ready).
//    On s2_load, S2 <= reduce(S1 operands) and S1 tag.
//    Otherwise, if out_ready, s2_valid <= 0.
//  - S1 advance: in_ready = !s1_valid || s2_load (combinational, no dependence on in_valid).
//    On in_valid&&in_ready, S1 <= {in_a, in_b, in_tag}, s1_valid <= 1.
//    Otherwise, if s2_load, s1_valid <= 0.
//  - Latency: an operand accepted at edge N appears with out_valid=1 after edge N+1,
//    when not stalled (2 register stages, 1 cycle from accept to out_valid).
//  - Throughput: 1 op/cycle when out_ready=1 continuously.
//    Simultaneous accept-in and drain-out while both stages are full is legal and loses nothing.
//  - Full: s1_valid=s2_valid=1 and out_ready=0 -> in_ready=0. No overwrite of either stage.
//  - Empty: both stages invalid -> in_ready=1, out_valid=0.
//  - Arithmetic: row_a + row_b (8-bit, mod 256) == in_a*in_b. Max product is 225, so there is no overflow.
//    The carry out of the downstream adder must be 0.
//  - Reduction: standard Dadda schedule, column heights 4 -> 3 -> 2, using only HA/FA cells.
//    Partial product pp[i][j] = in_a[i] & in_b[j], weight 2^(i+j).
//    Each row bit is a single-column value. Bit 7 may be 0 in either row.
//  - Ordering: results leave in acceptance order. Tags are never reordered or duplicated.
// STRUCTURE
//  - dadda_pkg: OP_W=4, ROW_W=8, localparam Dadda height sequence {3,2}, HA/FA cell interfaces.
//  - One sub-module: dadda_tree_4x4, purely combinational: (a[3:0], b[3:0]) -> (row_a[7:0], row_b[7:0]).
//    The top level holds only the S1/S2 registers and handshake logic.
//  - No combinational path from in_* to out_*.
//    The only combinational path from out_ready is out_ready -> in_ready.
// TESTING
//  1 Reset then idle -> out_valid=0, in_ready=1, rows=0.
//    Assert rst_n=0 with both stages full -> next cycle out_valid=0, nothing is emitted afterward.
//  2 in_a=15, in_b=15, tag=3, out_ready=1 -> one cycle later out_valid=1, row_a+row_b=225, out_tag=3.
//    Also a=0,b=9 -> 0; a=1,b=13 -> 13.
//  3 Exhaustive 256 pairs streamed back-to-back with out_ready=1 -> in_ready stays 1.
//    Every (row_a+row_b)==a*b, in order, and the sum never exceeds 225.
//  4 Backpressure: out_ready=0, send ops A(7x9) and B(12x5) -> in_ready=0 after B.
//    Rows for A (sum 63) held stable. Release -> A then B (sum 60), no loss or duplication.
//  5 Full-with-drain: both stages full, out_ready=1 and in_valid=1 in the same cycle.
//    -> new op accepted, old S2 emitted, order preserved (check tags 1,2,3).
//  6 Random valid/ready toggling, 10k ops vs reference model -> sums and tags match in order.
//    Outputs stable whenever out_valid&&!out_ready.

Source files
------------

// File: rtl/dadda_pkg.sv
// dadda_pkg
//   Shared constants and cell helpers for the 4x4 Dadda row reducer.
//   OP_W           operand width
//   ROW_W          width of each reduced output row
//   DADDA_HEIGHTS  target column heights per reduction stage (4 -> 3 -> 2)
//   cell_out_t     {sum, carry} result of one half/full adder cell
//   ha / fa        half adder and full adder cells
package dadda_pkg;

  localparam int unsigned OP_W         = 32'd4;
  localparam int unsigned ROW_W        = 32'd8;
  localparam int unsigned DADDA_STAGES = 32'd2;
  localparam int unsigned DADDA_HEIGHTS [0:1] = '{32'd3, 32'd2};

  typedef struct packed {
    logic sum;
    logic carry;
  } cell_out_t;

  function automatic cell_out_t ha(input logic x, input logic y);
    cell_out_t r;
    r.sum   = x ^ y;
    r.carry = x & y;
    return r;
  endfunction

  function automatic cell_out_t fa(input logic x, input logic y, input logic z);
    cell_out_t r;
    r.sum   = x ^ y ^ z;
    r.carry = (x & y) | (x & z) | (y & z);
    return r;
  endfunction

endpackage

// File: rtl/dadda_tree_4x4.sv
// dadda_tree_4x4
//   Purely combinational Dadda reduction of a 4x4 unsigned multiply down to
//   two 8-bit rows whose sum is a*b.
//   a, b          in   4  operands (unsigned)
//   row_a, row_b  out  8  reduced rows, one bit per column
//
//   Column heights of the partial-product matrix are 1,2,3,4,3,2,1.
//   Stage 1 (target 3): HA in column 3, HA in column 4.
//   Stage 2 (target 2): HA in column 2, FA in columns 3, 4 and 5.
//   Column 7 never receives a carry, so bit 7 of both rows is zero.
module dadda_tree_4x4
  import dadda_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [ROW_W-1:0] row_a,
  output logic [ROW_W-1:0] row_b
);

  // pp_s[i][j] = a[i] & b[j], weight 2^(i+j)
  logic [OP_W-1:0][OP_W-1:0] pp_s;

  // Partial product generation.
  always_comb begin
    pp_s = '0;
    for (int i = 0; i < int'(OP_W); i++) begin
      for (int j = 0; j < int'(OP_W); j++) begin
        pp_s[i][j] = a[i] & b[j];
      end
    end
  end

  // Stage 1: bring columns 3 and 4 down to height 3.
  cell_out_t st1_c3_s;
  cell_out_t st1_c4_s;
  assign st1_c3_s = ha(pp_s[3][0], pp_s[2][1]);
  assign st1_c4_s = ha(pp_s[3][1], pp_s[2][2]);

  // Stage 2: bring every column down to height 2.
  cell_out_t st2_c2_s;
  cell_out_t st2_c3_s;
  cell_out_t st2_c4_s;
  cell_out_t st2_c5_s;
  assign st2_c2_s = ha(pp_s[2][0], pp_s[1][1]);
  assign st2_c3_s = fa(st1_c3_s.sum, pp_s[1][2], pp_s[0][3]);
  assign st2_c4_s = fa(st1_c4_s.sum, pp_s[1][3], st1_c3_s.carry);
  assign st2_c5_s = fa(pp_s[3][2], pp_s[2][3], st1_c4_s.carry);

  // Row assembly: each bit position carries exactly one value of that column.
  assign row_a = {1'b0, pp_s[3][3], st2_c5_s.sum, st2_c4_s.sum,
                  st2_c3_s.sum, st2_c2_s.sum, pp_s[1][0], pp_s[0][0]};
  assign row_b = {1'b0, st2_c5_s.carry, st2_c4_s.carry, st2_c3_s.carry,
                  st2_c2_s.carry, pp_s[0][2], pp_s[0][1], 1'b0};

endmodule

// File: rtl/dadda_rows_4x4_pipe.sv
// dadda_rows_4x4_pipe
//   Two-stage elastic pipeline feeding the downstream carry-select adder.
//   S1 registers the operands, S2 registers the Dadda-reduced rows, so the
//   outputs are fully registered. row_a + row_b == in_a * in_b.
//   clk        in   1      clock, posedge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      operands accepted this cycle
//   in_a/in_b  in   4      unsigned operands
//   in_tag     in   TAG_W  sideband returned with the result
//   out_valid  out  1      rows valid
//   out_ready  in   1      downstream accepts rows
//   row_a/b    out  8      reduced rows
//   out_tag    out  TAG_W  tag of the rows on the output
module dadda_rows_4x4_pipe
  import dadda_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] row_a,
  output logic [ROW_W-1:0] row_b,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_r;
  logic [OP_W-1:0]  s1_a_r;
  logic [OP_W-1:0]  s1_b_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic             s2_valid_r;
  logic [ROW_W-1:0] s2_row_a_r;
  logic [ROW_W-1:0] s2_row_b_r;
  logic [TAG_W-1:0] s2_tag_r;

  logic [ROW_W-1:0] tree_row_a_s;
  logic [ROW_W-1:0] tree_row_b_s;
  logic             s2_load_s;
  logic             in_fire_s;

  // Reduction operates on registered operands, so in_* never reaches out_*.
  dadda_tree_4x4 u_tree (
    .a     (s1_a_r),
    .b     (s1_b_r),
    .row_a (tree_row_a_s),
    .row_b (tree_row_b_s)
  );

  // S2 takes S1 when S2 is empty or draining; in_ready follows so a full
  // pipe can accept and emit in the same cycle. out_ready -> in_ready is the
  // only combinational path through the block.
  assign s2_load_s = s1_valid_r & (~s2_valid_r | out_ready);
  assign in_ready  = ~s1_valid_r | s2_load_s;
  assign in_fire_s = in_valid & in_ready;

  // Stage 1 operand register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {OP_W{1'b0}};
      s1_b_r     <= {OP_W{1'b0}};
      s1_tag_r   <= {TAG_W{1'b0}};
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= in_a;
      s1_b_r     <= in_b;
      s1_tag_r   <= in_tag;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2 row register; holds while stalled so outputs stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_row_a_r <= {ROW_W{1'b0}};
      s2_row_b_r <= {ROW_W{1'b0}};
      s2_tag_r   <= {TAG_W{1'b0}};
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      s2_row_a_r <= tree_row_a_s;
      s2_row_b_r <= tree_row_b_s;
      s2_tag_r   <= s1_tag_r;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign out_valid = s2_valid_r;
  assign row_a     = s2_row_a_r;
  assign row_b     = s2_row_b_r;
  assign out_tag   = s2_tag_r;

endmodule
